// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the MIPS datapath register file and its scoreboard.
package mips_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int REG_ZERO   = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing port bundle of the register file.
interface reg_file_sb_if
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] RR1;
   logic [ADDR_W-1:0] RR2;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;
   logic              RdRdy1;
   logic              RdRdy2;
   logic [ADDR_W-1:0] WR;
   logic [DATA_W-1:0] WD;
   logic              RegWrite;
   logic              Reserve;
   logic [ADDR_W-1:0] RsvReg;
   logic              PendingAny;

   modport master (
      output RR1, RR2, WR, WD, RegWrite, Reserve, RsvReg,
      input  RD1, RD2, RdRdy1, RdRdy2, PendingAny
   );

   modport slave (
      input  RR1, RR2, WR, WD, RegWrite, Reserve, RsvReg,
      output RD1, RD2, RdRdy1, RdRdy2, PendingAny
   );
endinterface

// File: rtl/reg_file_sb_sb_bits.sv
// Pending-producer bit array; a reserve in the same cycle as a write wins.
module sb_bits
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_addr,
   input  logic                   set_en,
   input  logic [ADDR_W-1:0]      set_addr,
   output logic [(2**ADDR_W)-1:0] pending,
   output logic                   pending_any
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;

   always_comb begin
      pend_d = pend_q;
      if (clr_en) pend_d[clr_addr] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
      pend_d[REG_ZERO] = 1'b0;
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) pend_q <= '0;
      else          pend_q <= pend_d;
   end

   assign pending     = pend_q;
   assign pending_any = |pend_q;
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with r0 hardwired to zero, optional write bypass
// and a pending scoreboard for read-after-write stalls.
module reg_file_sb
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   reg_file_sb_if.slave bus
);
   localparam int                DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic              wr_en;
   logic              rsv_en;
   logic              byp1;
   logic              byp2;

   assign wr_en  = bus.RegWrite && (bus.WR != ZERO_ADDR);
   assign rsv_en = bus.Reserve && (bus.RsvReg != ZERO_ADDR);

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[bus.WR] <= bus.WD;
      end
   end

   sb_bits #(.ADDR_W(ADDR_W)) u_sb_bits (
      .clock       (clock),
      .reset_n     (reset_n),
      .clr_en      (wr_en),
      .clr_addr    (bus.WR),
      .set_en      (rsv_en),
      .set_addr    (bus.RsvReg),
      .pending     (pending),
      .pending_any (bus.PendingAny)
   );

   // Bypass only matters for nonzero addresses; r0 is resolved first below.
   assign byp1 = (BYPASS != 0) && bus.RegWrite && (bus.WR == bus.RR1);
   assign byp2 = (BYPASS != 0) && bus.RegWrite && (bus.WR == bus.RR2);

   assign bus.RD1 = (bus.RR1 == ZERO_ADDR) ? '0 : (byp1 ? bus.WD : regs[bus.RR1]);
   assign bus.RD2 = (bus.RR2 == ZERO_ADDR) ? '0 : (byp2 ? bus.WD : regs[bus.RR2]);

   assign bus.RdRdy1 = (bus.RR1 == ZERO_ADDR) || byp1 || !pending[bus.RR1];
   assign bus.RdRdy2 = (bus.RR2 == ZERO_ADDR) || byp2 || !pending[bus.RR2];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with bypass, one without, driven identically.
module tb_reg_file_sb;
   logic clock;
   logic reset_n;

   logic [2:0]  rr1, rr2, wr, rsvreg;
   logic [15:0] wd;
   logic        we, rsv;

   int checks = 0;
   int passes = 0;

   logic [15:0] m_regs [8];
   logic [7:0]  m_pend;

   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) b0 ();
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(b0));
   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(b1));

   assign b0.RR1 = rr1;  assign b1.RR1 = rr1;
   assign b0.RR2 = rr2;  assign b1.RR2 = rr2;
   assign b0.WR = wr;    assign b1.WR = wr;
   assign b0.WD = wd;    assign b1.WD = wd;
   assign b0.RegWrite = we;  assign b1.RegWrite = we;
   assign b0.Reserve = rsv;  assign b1.Reserve = rsv;
   assign b0.RsvReg = rsvreg; assign b1.RsvReg = rsvreg;

   logic [15:0] o_rd1 [2];
   logic [15:0] o_rd2 [2];
   logic        o_rdy1 [2];
   logic        o_rdy2 [2];
   logic        o_pany [2];
   assign o_rd1[0] = b0.RD1;   assign o_rd1[1] = b1.RD1;
   assign o_rd2[0] = b0.RD2;   assign o_rd2[1] = b1.RD2;
   assign o_rdy1[0] = b0.RdRdy1; assign o_rdy1[1] = b1.RdRdy1;
   assign o_rdy2[0] = b0.RdRdy2; assign o_rdy2[1] = b1.RdRdy2;
   assign o_pany[0] = b0.PendingAny; assign o_pany[1] = b1.PendingAny;

   initial clock = 1'b1;
   always #5 clock = ~clock;

   function automatic logic [15:0] exp_rd(input logic [2:0] rr, input int d);
      if (rr == 3'd0) return 16'h0000;
      if (d == 1 && we && wr == rr) return wd;
      return m_regs[rr];
   endfunction

   function automatic logic exp_rdy(input logic [2:0] rr, input int d);
      if (rr == 3'd0) return 1'b1;
      if (d == 1 && we && wr == rr) return 1'b1;
      return ~m_pend[rr];
   endfunction

   task automatic drive(input logic [2:0] a1, input logic [2:0] a2, input logic w_en,
                        input logic [2:0] w_a, input logic [15:0] w_d,
                        input logic r_en, input logic [2:0] r_a);
      rr1 = a1; rr2 = a2; we = w_en; wr = w_a; wd = w_d; rsv = r_en; rsvreg = r_a;
   endtask

   // Applies the current inputs at the falling edge, in model and DUT alike.
   task automatic tick();
      @(negedge clock);
      if (we && wr != 3'd0) begin
         m_regs[wr] = wd;
         m_pend[wr] = 1'b0;
      end
      if (rsv && rsvreg != 3'd0) m_pend[rsvreg] = 1'b1;
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_pend = 8'h00;
   endtask

   task automatic test_reset();
      drive(3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'h0000) $display("FAIL rst_hold_rd1 dut%0d got %h want 0000", d, o_rd1[d]); else passes++;
         checks++; if (o_rdy1[d] !== 1'b1) $display("FAIL rst_hold_rdy1 dut%0d got %b want 1", d, o_rdy1[d]); else passes++;
      end
      @(posedge clock); #1 reset_n = 1'b1;
      drive(3'd3, 3'd5, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd5);
      tick();
      drive(3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'hBEEF) $display("FAIL pre_rst_rd1 dut%0d got %h want beef", d, o_rd1[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b1) $display("FAIL pre_rst_pany dut%0d got %b want 1", d, o_pany[d]); else passes++;
      end
      @(posedge clock); #2 reset_n = 1'b0;
      #1;
      model_clear();
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'h0000) $display("FAIL async_rst_rd1 dut%0d got %h want 0000", d, o_rd1[d]); else passes++;
         checks++; if (o_rdy1[d] !== 1'b1 || o_rdy2[d] !== 1'b1) $display("FAIL async_rst_rdy dut%0d got %b%b want 11", d, o_rdy1[d], o_rdy2[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b0) $display("FAIL async_rst_pany dut%0d got %b want 0", d, o_pany[d]); else passes++;
      end
      @(posedge clock); #1 reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      drive(3'd0, 3'd5, 1'b1, 3'd5, 16'h0F0F, 1'b0, 3'd0);
      tick();
      drive(3'd0, 3'd5, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd2[d] !== (d == 1 ? 16'h1234 : 16'h0F0F)) $display("FAIL wr_same_cycle_rd2 dut%0d got %h want %h", d, o_rd2[d], (d == 1 ? 16'h1234 : 16'h0F0F)); else passes++;
      end
      tick();
      drive(3'd0, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd2[d] !== 16'h1234) $display("FAIL wr_after_edge_rd2 dut%0d got %h want 1234", d, o_rd2[d]); else passes++;
      end
   endtask

   task automatic test_reg_zero();
      drive(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'h0000) $display("FAIL r0_bypass_rd1 dut%0d got %h want 0000", d, o_rd1[d]); else passes++;
      end
      tick();
      drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'h0000 || o_rdy1[d] !== 1'b1) $display("FAIL r0_after_rd1 dut%0d got %h/%b want 0000/1", d, o_rd1[d], o_rdy1[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b0) $display("FAIL r0_pany dut%0d got %b want 0", d, o_pany[d]); else passes++;
      end
   endtask

   task automatic test_scoreboard();
      drive(3'd2, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
      tick();
      drive(3'd2, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rdy1[d] !== 1'b0) $display("FAIL sb_reserved_rdy1 dut%0d got %b want 0", d, o_rdy1[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b1) $display("FAIL sb_reserved_pany dut%0d got %b want 1", d, o_pany[d]); else passes++;
      end
      drive(3'd2, 3'd0, 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rdy1[d] !== (d == 1)) $display("FAIL sb_wb_cycle_rdy1 dut%0d got %b want %0d", d, o_rdy1[d], (d == 1)); else passes++;
      end
      tick();
      drive(3'd2, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rdy1[d] !== 1'b1 || o_rd1[d] !== 16'h00AA) $display("FAIL sb_written dut%0d got %b/%h want 1/00aa", d, o_rdy1[d], o_rd1[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b0) $display("FAIL sb_written_pany dut%0d got %b want 0", d, o_pany[d]); else passes++;
      end
   endtask

   task automatic test_collision();
      drive(3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
      tick();
      drive(3'd4, 3'd0, 1'b1, 3'd4, 16'h5555, 1'b1, 3'd4);
      tick();
      drive(3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'h5555 || o_rdy1[d] !== 1'b0) $display("FAIL coll_same_reg dut%0d got %h/%b want 5555/0", d, o_rd1[d], o_rdy1[d]); else passes++;
      end
      drive(3'd6, 3'd1, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd6);
      tick();
      drive(3'd6, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rdy1[d] !== 1'b0) $display("FAIL coll_r6_rdy dut%0d got %b want 0", d, o_rdy1[d]); else passes++;
         checks++; if (o_rd2[d] !== 16'h1111 || o_rdy2[d] !== 1'b1) $display("FAIL coll_r1_data dut%0d got %h/%b want 1111/1", d, o_rd2[d], o_rdy2[d]); else passes++;
         checks++; if (o_pany[d] !== 1'b1) $display("FAIL coll_pany dut%0d got %b want 1", d, o_pany[d]); else passes++;
      end
   endtask

   task automatic test_dual_port();
      logic [15:0] v1, v2;
      drive(3'd7, 3'd7, 1'b1, 3'd7, 16'hC0DE, 1'b0, 3'd0);
      tick();
      drive(3'd7, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_rd1[d] !== 16'hC0DE || o_rd2[d] !== 16'hC0DE) $display("FAIL dual_same dut%0d got %h/%h want c0de", d, o_rd1[d], o_rd2[d]); else passes++;
      end
      for (int a = 1; a < 8; a++) begin
         drive(3'd0, 3'd0, 1'b1, 3'(a), 16'hA000 + 16'(a) * 16'h0111, 1'b0, 3'd0);
         tick();
      end
      for (int a = 0; a < 8; a++) begin
         drive(3'(a), 3'(7 - a), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
         #1;
         v1 = (a == 0) ? 16'h0000 : 16'hA000 + 16'(a) * 16'h0111;
         v2 = (a == 7) ? 16'h0000 : 16'hA000 + 16'(7 - a) * 16'h0111;
         for (int d = 0; d < 2; d++) begin
            checks++; if (o_rd1[d] !== v1 || o_rd2[d] !== v2) $display("FAIL sweep_a%0d dut%0d got %h/%h want %h/%h", a, d, o_rd1[d], o_rd2[d], v1, v2); else passes++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
               3'($urandom_range(0, 7)));
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_rd1[d] !== exp_rd(rr1, d) || o_rd2[d] !== exp_rd(rr2, d) ||
                o_rdy1[d] !== exp_rdy(rr1, d) || o_rdy2[d] !== exp_rdy(rr2, d) || o_pany[d] !== (|m_pend))
               $display("FAIL rand_n%0d dut%0d got %h %h %b %b %b want %h %h %b %b %b", n, d,
                        o_rd1[d], o_rd2[d], o_rdy1[d], o_rdy2[d], o_pany[d],
                        exp_rd(rr1, d), exp_rd(rr2, d), exp_rdy(rr1, d), exp_rdy(rr2, d), |m_pend);
            else passes++;
         end
         tick();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      model_clear();
      @(posedge clock);
      test_reset();
      test_write_read();
      test_reg_zero();
      test_scoreboard();
      test_collision();
      test_dual_port();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the team's 4x16 register file for the simplified MIPS datapath.
- Generalises data width and depth, and keeps register 0 hardwired to zero.
- Adds:
  - asynchronous active-low clear of all registers;
  - optional write-to-read bypass;
  - a per-register pending scoreboard, so the multi-cycle/pipelined control can stall on read-after-write hazards.
- Sits between decode (read addresses, reserve) and writeback (write port).

Parameters:
- DATA_W, 16: width of each register and of the data ports.
- ADDR_W, 3: register address width; depth = 2**ADDR_W.
- BYPASS, 1: 1 = a read of the register being written this cycle returns WD combinationally; 0 = reads see only stored contents.

Ports:
- clock  in  1  system clock; all state updates on the falling edge.
- reset_n  in  1  asynchronous active-low reset.
- RR1  in  ADDR_W  read address, port 1.
- RR2  in  ADDR_W  read address, port 2.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- RdRdy1  out  1  register at RR1 has no outstanding producer.
- RdRdy2  out  1  register at RR2 has no outstanding producer.
- WR  in  ADDR_W  write address.
- WD  in  DATA_W  write data.
- RegWrite  in  1  write enable.
- Reserve  in  1  mark register RsvReg as pending (issued producer).
- RsvReg  in  ADDR_W  register to reserve.
- PendingAny  out  1  OR of all pending bits.

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-low, reset_n.
- Storage: 2**ADDR_W registers of DATA_W bits, plus 2**ADDR_W pending bits.
- Reset (reset_n=0, asynchronous, independent of clock):
  - all registers = 0; all pending bits = 0.
  - Outputs during reset: RD1=RD2=0, RdRdy1=RdRdy2=1, PendingAny=0.
  - On deassertion, the first state change occurs at the next falling clock edge.
  - Reset mid-operation discards all reservations.
- Register 0:
  - reads always return 0 and RdRdy always 1;
  - writes and reserves to address 0 are ignored; its pending bit is constant 0.
- Write (falling edge, RegWrite=1, WR!=0):
  - Regs[WR] <= WD;
  - pending[WR] <= 0, unless the reserve rule below applies.
- Reserve (falling edge, Reserve=1, RsvReg!=0): pending[RsvReg] <= 1.
- Simultaneous write and reserve:
  - Different registers: both take effect.
  - Same register: data is written and the pending bit ends at 1 (the new producer wins).
- Read (combinational, zero latency):
  - RDn = 0 if RRn==0.
  - Otherwise, if BYPASS and RegWrite and WR==RRn, RDn = WD.
  - Otherwise RDn = Regs[RRn].
  - Both ports may address the same register; both return identical data.
- Ready:
  - RdRdyn = 1 if RRn==0.
  - Otherwise, if BYPASS and RegWrite and WR==RRn, RdRdyn = 1.
  - Otherwise RdRdyn = ~pending[RRn].
  - Control must stall on RdRdyn=0; the block itself never blocks a write.
- Unreserved writes:
  - A write to a register that was never reserved is legal.
  - Its pending bit is unaffected (stays 0).
- PendingAny: combinational OR of the stored pending bits. Not bypassed.
- Width rules: no arithmetic in the block; addresses are used directly and wrap-free, since depth = 2**ADDR_W exactly.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W defaults;
  - a REG_ZERO constant (address 0).
- Sub-module sb_bits: the pending-bit array with async clear, set/clear priority, and PendingAny.
- The top module holds the data array, the read/bypass muxes, and the ready muxes.

Test Plan:
1. Reset: pulse reset_n low mid-cycle after writing 16'hBEEF to r3 -> RD1 reads r3 = 16'h0000 immediately (asynchronously); RdRdy1=1; PendingAny=0.
2. Write then read: RegWrite=1, WR=5, WD=16'h1234 -> during the same cycle with BYPASS=1, RD2 (RR2=5) = 16'h1234. With BYPASS=0, RD2 = old value until after the falling edge, then 16'h1234.
3. Register zero: write WR=0, WD=16'hFFFF and Reserve RsvReg=0 -> RD1 (RR1=0) = 0, RdRdy1=1, PendingAny=0.
4. Scoreboard: Reserve r2 -> RdRdy1 (RR1=2) = 0 and PendingAny=1 after the edge. Write r2=16'h00AA -> RdRdy1=1, RD1=16'h00AA, PendingAny=0.
5. Collision: r4 pending, then in one cycle RegWrite WR=4, WD=16'h5555 and Reserve RsvReg=4 -> after the edge RD=16'h5555, RdRdy=0. Separately, reserve r6 while writing r1 -> r6 pending, r1 updated.
6. Dual port: RR1=RR2=7 after writing 16'hC0DE -> RD1=RD2=16'hC0DE. Sweep all 8 addresses with distinct values and read them back.
